input_command_unit: RTL and testbench

Upstream front-end for the grid controller: takes five raw, asynchronous push-button lines and converts them into single, debounced, prioritised 4-bit move commands.
- Adds auto-repeat for held left/right/down.
- Presents one command at a time on a valid/ack handshake, feeding the grid controller's `controller_in` bus.
- Holds `cmd` at 4'b0000 whenever no command is pending, so a level-sampling consumer sees "no action".

---
 rtl/input_command_unit_if.sv | 24 ++
 rtl/input_command_unit.sv | 128 ++++++++++++
 tb/tb_input_command_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/input_command_unit_if.sv
// Button/command bus between the raw push-button front-end and the grid controller.
interface input_command_unit_if;
  logic [4:0] btn_raw;
  logic       cmd_ack;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       overrun;

  modport master (
    input  btn_raw,
    input  cmd_ack,
    output cmd,
    output cmd_valid,
    output overrun
  );

  modport slave (
    output btn_raw,
    output cmd_ack,
    input  cmd,
    input  cmd_valid,
    input  overrun
  );
endinterface

// File: rtl/input_command_unit.sv
// Debounces five async buttons into prioritised 4-bit move commands with auto-repeat.
// Press-to-command latency DEBOUNCE_CYCLES+2; one command held until ack, later events dropped and flagged.
module input_command_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 16
) (
  input logic                  clk,
  input logic                  reset,
  input_command_unit_if.master bus
);
  localparam logic [15:0] DB_MAX     = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] REP_FIRST  = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] REP_RELOAD = 16'(REPEAT_DELAY - REPEAT_RATE);

  typedef enum logic {IDLE, PENDING} state_t;

  logic [4:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0]       stable_q, stable_d, stable_dly_q, stable_dly_d;
  logic [4:0][15:0] db_cnt_q, db_cnt_d;
  logic [15:0]      rep_cnt_q, rep_cnt_d;
  state_t           state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             vld_q, vld_d, ovr_q, ovr_d;

  logic [4:0] press, rep_btn, ev;
  logic       changed, rep_held, rep_fire, ev_any;
  logic [3:0] ev_code;

  always_comb begin
    sync1_d      = bus.btn_raw;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    db_cnt_d     = '0;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) stable_d[i] = sync2_q[i];
        else                       db_cnt_d[i] = db_cnt_q[i] + 16'd1;
      end
    end
  end

  // Repeat source priority follows command priority: down > left > right.
  always_comb begin
    press    = stable_q & ~stable_dly_q;
    changed  = (stable_q != stable_dly_q);
    rep_held = stable_q[3] | stable_q[0] | stable_q[1];
    if (stable_q[3])      rep_btn = 5'b01000;
    else if (stable_q[0]) rep_btn = 5'b00001;
    else if (stable_q[1]) rep_btn = 5'b00010;
    else                  rep_btn = 5'b00000;
    rep_fire = rep_held && !changed && (rep_cnt_q == REP_FIRST);

    if (changed || !rep_held) rep_cnt_d = '0;
    else if (rep_fire)        rep_cnt_d = REP_RELOAD;
    else                      rep_cnt_d = rep_cnt_q + 16'd1;

    ev     = press | (rep_fire ? rep_btn : 5'b00000);
    ev_any = |ev;
    if (ev[4])      ev_code = 4'b0100;
    else if (ev[2]) ev_code = 4'b0011;
    else if (ev[3]) ev_code = 4'b0101;
    else if (ev[0]) ev_code = 4'b0001;
    else if (ev[1]) ev_code = 4'b0010;
    else            ev_code = 4'b0000;
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (ev_any) begin
          cmd_d   = ev_code;
          vld_d   = 1'b1;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (bus.cmd_ack) begin
          if (ev_any) begin
            cmd_d = ev_code;
          end else begin
            cmd_d   = 4'b0000;
            vld_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (ev_any) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      db_cnt_q     <= '0;
      rep_cnt_q    <= '0;
      state_q      <= IDLE;
      cmd_q        <= 4'b0000;
      vld_q        <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      db_cnt_q     <= db_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      vld_q        <= vld_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = vld_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_input_command_unit.sv
// Directed bench for input_command_unit: vector table plus hand-written repeat/bounce/overrun/reset sequences.
module tb_input_command_unit;
  localparam int D  = 16;
  localparam int RD = 64;
  localparam int RR = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  input_command_unit_if bus_if();

  input_command_unit #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  typedef struct {
    string      name;
    logic [4:0] btn;
    logic       ack;
    int         ncyc;
    logic [3:0] cmd;
    logic       vld;
    logic       ovr;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   t;
  vec_t vecs[19];
  int   load_t[$];
  logic [3:0] load_c[$];
  int   exp_t[$];

  function automatic vec_t mk(input string n, input logic [4:0] b, input logic a, input int c,
                              input logic [3:0] ec, input logic ev, input logic eo);
    vec_t v;
    v.name = n; v.btn = b; v.ack = a; v.ncyc = c; v.cmd = ec; v.vld = ev; v.ovr = eo;
    return v;
  endfunction

  task automatic step(input logic [4:0] b, input logic a);
    bus_if.btn_raw = b;
    bus_if.cmd_ack = a;
    @(posedge clk);
    t++;
    #1;
  endtask

  // Acks any command one cycle after it is loaded and logs every load.
  task automatic mon_step(input logic [4:0] b);
    logic a;
    a = bus_if.cmd_valid;
    step(b, a);
    if (bus_if.cmd_valid) begin
      load_t.push_back(t);
      load_c.push_back(bus_if.cmd);
    end
  endtask

  task automatic check(input string name, input logic [3:0] c, input logic v, input logic o);
    n_tests++;
    if (bus_if.cmd !== c || bus_if.cmd_valid !== v || bus_if.overrun !== o) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got cmd=%b vld=%b ovr=%b, want cmd=%b vld=%b ovr=%b",
               name, t, bus_if.cmd, bus_if.cmd_valid, bus_if.overrun, c, v, o);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.btn_raw = '0;
    bus_if.cmd_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    t = -1;
    load_t.delete();
    load_c.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk("clean_wait",   5'b00001, 1'b0, 18, 4'h0, 1'b0, 1'b0);
    vecs[1]  = mk("clean_load",   5'b00001, 1'b0, 1,  4'h1, 1'b1, 1'b0);
    vecs[2]  = mk("clean_hold",   5'b00001, 1'b0, 1,  4'h1, 1'b1, 1'b0);
    vecs[3]  = mk("clean_ack",    5'b00001, 1'b1, 1,  4'h0, 1'b0, 1'b0);
    vecs[4]  = mk("clean_norpt",  5'b00001, 1'b0, 19, 4'h0, 1'b0, 1'b0);
    vecs[5]  = mk("clean_rel",    5'b00000, 1'b0, 30, 4'h0, 1'b0, 1'b0);
    vecs[6]  = mk("idle_ack",     5'b00000, 1'b1, 5,  4'h0, 1'b0, 1'b0);
    vecs[7]  = mk("glitch15",     5'b00100, 1'b0, 15, 4'h0, 1'b0, 1'b0);
    vecs[8]  = mk("glitch15_end", 5'b00000, 1'b0, 30, 4'h0, 1'b0, 1'b0);
    vecs[9]  = mk("pulse16",      5'b00100, 1'b0, 16, 4'h0, 1'b0, 1'b0);
    vecs[10] = mk("pulse16_wait", 5'b00000, 1'b0, 2,  4'h0, 1'b0, 1'b0);
    vecs[11] = mk("pulse16_load", 5'b00000, 1'b0, 1,  4'h3, 1'b1, 1'b0);
    vecs[12] = mk("pulse16_ack",  5'b00000, 1'b1, 1,  4'h0, 1'b0, 1'b0);
    vecs[13] = mk("pulse16_end",  5'b00000, 1'b0, 30, 4'h0, 1'b0, 1'b0);
    vecs[14] = mk("prio_wait",    5'b10001, 1'b0, 18, 4'h0, 1'b0, 1'b0);
    vecs[15] = mk("prio_load",    5'b10001, 1'b0, 1,  4'h4, 1'b1, 1'b0);
    vecs[16] = mk("prio_ack",     5'b10001, 1'b1, 1,  4'h0, 1'b0, 1'b0);
    vecs[17] = mk("prio_noleft",  5'b10001, 1'b0, 20, 4'h0, 1'b0, 1'b0);
    vecs[18] = mk("prio_rel",     5'b00000, 1'b0, 30, 4'h0, 1'b0, 1'b0);

    do_reset();
    check("reset_vals", 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      for (int c = 0; c < vecs[i].ncyc; c++) step(vecs[i].btn, vecs[i].ack);
      check(vecs[i].name, vecs[i].cmd, vecs[i].vld, vecs[i].ovr);
    end

    // Bounce: rotate toggles every 5 cycles for 60 cycles, then stays high.
    do_reset();
    for (int i = 0; i < 120; i++)
      mon_step((i >= 60 || ((i / 5) % 2) == 0) ? 5'b00100 : 5'b00000);
    for (int i = 0; i < 40; i++) mon_step(5'b00000);
    check_int("bounce_count", load_t.size(), 1);
    if (load_t.size() > 0) begin
      check_int("bounce_edge", load_t[0], 60 + D + 2);
      check_int("bounce_code", int'(load_c[0]), 3);
    end
    check("bounce_ovr", 4'h0, 1'b0, 1'b0);

    // Auto-repeat: right held for 200 cycles; stable level drops D+1 edges after release.
    do_reset();
    for (int i = 0; i < 200; i++) mon_step(5'b00010);
    for (int i = 0; i < 60; i++) mon_step(5'b00000);
    exp_t.delete();
    exp_t.push_back(D + 2);
    for (int e = D + 2 + RD; e <= 200 + D + 1; e += RR) exp_t.push_back(e);
    check_int("rpt_count", load_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < load_t.size(); i++) begin
      check_int($sformatf("rpt_edge%0d", i), load_t[i], exp_t[i]);
      check_int($sformatf("rpt_code%0d", i), int'(load_c[i]), 2);
    end
    check("rpt_ovr", 4'h0, 1'b0, 1'b0);

    // Overrun: down pending, rotate pressed 30 cycles later without ack.
    do_reset();
    for (int i = 0; i < 70; i++) begin
      step({1'b0, (i < 40), (i >= 30 && i < 50), 2'b00}, 1'b0);
      if (t == 40) check("ovr_before", 4'h5, 1'b1, 1'b0);
    end
    check("ovr_set", 4'h5, 1'b1, 1'b1);
    step(5'b00000, 1'b1);
    check("ovr_after_ack", 4'h0, 1'b0, 1'b1);
    repeat (10) step(5'b00000, 1'b0);
    check("ovr_sticky", 4'h0, 1'b0, 1'b1);
    do_reset();
    check("ovr_cleared", 4'h0, 1'b0, 1'b0);

    // Reset mid-operation with left still held.
    for (int i = 0; i < 19; i++) step(5'b00001, 1'b0);
    check("rst_pending", 4'h1, 1'b1, 1'b0);
    reset = 1'b1;
    step(5'b00001, 1'b0);
    check("rst_clear", 4'h0, 1'b0, 1'b0);
    step(5'b00001, 1'b0);
    reset = 1'b0;
    t = -1;
    for (int i = 0; i < 18; i++) step(5'b00001, 1'b0);
    check("rst_wait", 4'h0, 1'b0, 1'b0);
    step(5'b00001, 1'b0);
    check("rst_reload", 4'h1, 1'b1, 1'b0);
    step(5'b00001, 1'b1);
    check("rst_ack", 4'h0, 1'b0, 1'b0);
    repeat (20) step(5'b00001, 1'b0);
    check("rst_single", 4'h0, 1'b0, 1'b0);
    repeat (30) step(5'b00000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
